video_rect_fill: RTL and testbench

- Rectangle fill engine sitting directly upstream of the video controller's framebuffer write port.
- Accepts one fill command (origin, size, colour) over a valid/ready handshake.
- Clips the rectangle to the 800x600 active area.
- Emits one framebuffer write per clock (sig_write/pixel/color) in row-major order, with linear address = y*H_ACTIVE + x.

---
 rtl/video_rect_fill.sv | 180 ++++++++++++++++++
 tb/tb_video_rect_fill.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_rect_fill.sv
// rtl/video_rect_fill.sv - rectangle fill engine feeding the framebuffer write port
module video_rect_fill #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int ADDR_W   = 20,
  parameter int COLOR_W  = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [10:0]        cmd_x,
  input  logic [9:0]         cmd_y,
  input  logic [10:0]        cmd_w,
  input  logic [9:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               sig_write,
  output logic [ADDR_W-1:0]  pixel,
  output logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, FINISH} state_t;

  localparam logic [11:0]       H12      = 12'(H_ACTIVE);
  localparam logic [11:0]       V12      = 12'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STRIDE = ADDR_W'(H_ACTIVE);

  state_t state_q, state_d;

  // Captured command fields
  logic [10:0]        x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic [10:0]        w_q, w_d;
  logic [9:0]         h_q, h_d;
  logic [COLOR_W-1:0] col_q, col_d;

  // Fill walk: column/row counters and the address of the current row start
  logic [10:0]        c_q, c_d;
  logic [9:0]         r_q, r_d;
  logic [ADDR_W-1:0]  base_q, base_d;

  // Registered outputs
  logic               ready_q, ready_d;
  logic               write_q, write_d;
  logic [ADDR_W-1:0]  pixel_q, pixel_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Clipping in 12 bits so that the subtractions and compares never wrap
  logic [11:0]       x12, y12, w12, h12, room_w, room_h, cw12, ch12;
  logic              empty, last_col, last_row, accept;
  logic [ADDR_W-1:0] row_base;

  assign accept   = cmd_valid && ready_q;
  assign x12      = {1'b0, x_q};
  assign y12      = {2'b0, y_q};
  assign w12      = {1'b0, w_q};
  assign h12      = {2'b0, h_q};
  assign room_w   = H12 - x12;
  assign room_h   = V12 - y12;
  assign empty    = (x12 >= H12) || (y12 >= V12) || (w12 == 12'd0) || (h12 == 12'd0);
  assign cw12     = (w12 < room_w) ? w12 : room_w;
  assign ch12     = (h12 < room_h) ? h12 : room_h;
  assign last_col = ({1'b0, c_q} == cw12 - 12'd1);
  assign last_row = ({2'b0, r_q} == ch12 - 12'd1);
  // Only used in SETUP; the fill loop itself advances by adding the stride
  assign row_base = ADDR_W'(y_q) * H_STRIDE + ADDR_W'(x_q);

  // State and all registered values; reset abandons any fill immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      c_q     <= '0;
      r_q     <= '0;
      base_q  <= '0;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      pixel_q <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      c_q     <= c_d;
      r_q     <= r_d;
      base_q  <= base_d;
      ready_q <= ready_d;
      write_q <= write_d;
      pixel_q <= pixel_d;
      color_q <= color_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: IDLE -> SETUP -> FILL (skipped when clipped empty) -> FINISH -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = empty ? FINISH : FILL;
      FILL:    if (last_col && last_row) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; outputs are decoded from the next state so they stay registered
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    c_d     = c_q;
    r_d     = r_q;
    base_d  = base_q;
    pixel_d = pixel_q;
    color_d = color_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          x_d   = cmd_x;
          y_d   = cmd_y;
          w_d   = cmd_w;
          h_d   = cmd_h;
          col_d = cmd_color;
        end
      end
      SETUP: begin
        if (!empty) begin
          c_d     = '0;
          r_d     = '0;
          base_d  = row_base;
          pixel_d = row_base;
          color_d = col_q;
        end
      end
      FILL: begin
        if (!last_col) begin
          c_d     = c_q + 11'd1;
          pixel_d = pixel_q + ADDR_W'(1);
        end else if (!last_row) begin
          c_d     = '0;
          r_d     = r_q + 10'd1;
          base_d  = base_q + H_STRIDE;
          pixel_d = base_q + H_STRIDE;
        end
      end
      default: ;
    endcase

    ready_d = (state_d == IDLE);
    write_d = (state_d == FILL);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FINISH);
  end

  assign cmd_ready = ready_q;
  assign sig_write = write_q;
  assign pixel     = pixel_q;
  assign color     = color_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_video_rect_fill.sv
// tb/tb_video_rect_fill.sv - directed self-checking bench for video_rect_fill
module tb_video_rect_fill;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [10:0] cmd_x = '0;
  logic [9:0]  cmd_y = '0;
  logic [10:0] cmd_w = '0;
  logic [9:0]  cmd_h = '0;
  logic [23:0] cmd_color = '0;
  logic        sig_write;
  logic [19:0] pixel;
  logic [23:0] color;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int wr_pix[$];
  int wr_col[$];
  int wr_cyc[$];
  int busy_cyc[$];

  video_rect_fill dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .sig_write(sig_write), .pixel(pixel), .color(color), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write and busy cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (sig_write) begin
      wr_pix.push_back(int'(pixel));
      wr_col.push_back(int'(color));
      wr_cyc.push_back(cyc);
    end
    if (busy) busy_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_pix.delete();
    wr_col.delete();
    wr_cyc.delete();
    busy_cyc.delete();
  endtask

  // Called at a negedge; returns acceptance cycle t and leaves time at the negedge of t+1
  task automatic issue(input logic [10:0] x, input logic [9:0] y, input logic [10:0] w,
                       input logic [9:0] h, input logic [23:0] col, input bit hold, output int t);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = col;
    cmd_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    check("accepted", 64'(t >= 0), 64'd1);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int i = 0; i < 20000; i++) begin
      if (done) begin
        d = cyc;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", 64'(d >= 0), 64'd1);
    #1;
  endtask

  task automatic run_cmd(input logic [10:0] x, input logic [9:0] y, input logic [10:0] w,
                         input logic [9:0] h, input logic [23:0] col, output int t, output int d);
    @(negedge clk);
    clear_log();
    issue(x, y, w, h, col, 1'b0, t);
    wait_done(d);
  endtask

  int t, t2, d, errs;
  int ex[4] = '{0, 0, 800, 10};
  int ey[4] = '{0, 0, 5, 600};
  int ew[4] = '{0, 4, 2, 2};
  int eh[4] = '{3, 0, 2, 2};
  int cp[10] = '{8795, 8796, 8797, 8798, 8799, 9595, 9596, 9597, 9598, 9599};

  initial begin
    // Reset values
    #12;
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_write", 64'(sig_write), 64'd0);
    check("rst_pixel", 64'(pixel), 64'd0);
    check("rst_color", 64'(color), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    // 2x2 at origin
    run_cmd(11'd0, 10'd0, 11'd2, 10'd2, 24'hFF0000, t, d);
    check("r2_count", 64'(wr_pix.size()), 64'd4);
    if (wr_pix.size() == 4) begin
      check("r2_p0", 64'(wr_pix[0]), 64'd0);
      check("r2_p1", 64'(wr_pix[1]), 64'd1);
      check("r2_p2", 64'(wr_pix[2]), 64'd800);
      check("r2_p3", 64'(wr_pix[3]), 64'd801);
      check("r2_col", 64'(wr_col[3]), 64'hFF0000);
      check("r2_c0", 64'(wr_cyc[0]), 64'(t + 2));
      check("r2_c3", 64'(wr_cyc[3]), 64'(t + 5));
    end
    check("r2_done", 64'(d), 64'(t + 6));
    check("r2_ready_done", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("r2_ready_next", 64'(cmd_ready), 64'd1);

    // Bottom-right corner clip
    run_cmd(11'd798, 10'd599, 11'd5, 10'd3, 24'h00AA55, t, d);
    check("cc_count", 64'(wr_pix.size()), 64'd2);
    if (wr_pix.size() == 2) begin
      check("cc_p0", 64'(wr_pix[0]), 64'd479998);
      check("cc_p1", 64'(wr_pix[1]), 64'd479999);
      check("cc_done", 64'(d), 64'(wr_cyc[1] + 1));
    end

    // Right-edge clip over two rows
    run_cmd(11'd795, 10'd10, 11'd10, 10'd2, 24'h0F0F0F, t, d);
    check("re_count", 64'(wr_pix.size()), 64'd10);
    errs = 0;
    for (int i = 0; i < 10 && i < wr_pix.size(); i++)
      if (wr_pix[i] != cp[i] || wr_cyc[i] != t + 2 + i) errs++;
    check("re_seq", 64'(errs), 64'd0);
    check("re_done", 64'(d), 64'(t + 12));

    // Empty commands
    for (int k = 0; k < 4; k++) begin
      run_cmd(11'(ex[k]), 10'(ey[k]), 11'(ew[k]), 10'(eh[k]), 24'h777777, t, d);
      check("em_writes", 64'(wr_pix.size()), 64'd0);
      check("em_done", 64'(d), 64'(t + 2));
      check("em_busy_len", 64'(busy_cyc.size()), 64'd2);
      if (busy_cyc.size() == 2) begin
        check("em_busy_first", 64'(busy_cyc[0]), 64'(t + 1));
        check("em_busy_last", 64'(busy_cyc[1]), 64'(t + 2));
      end
    end

    // Full-width band of 20 lines
    run_cmd(11'd0, 10'd0, 11'd800, 10'd20, 24'h123456, t, d);
    check("fw_count", 64'(wr_pix.size()), 64'd16000);
    errs = 0;
    for (int i = 0; i < wr_pix.size(); i++)
      if (wr_pix[i] != i || wr_cyc[i] != t + 2 + i || wr_col[i] != 'h123456) errs++;
    check("fw_seq", 64'(errs), 64'd0);
    check("fw_done", 64'(d), 64'(t + 16002));

    // Reset in the middle of a 10x10 fill
    @(negedge clk);
    clear_log();
    issue(11'd0, 10'd0, 11'd10, 10'd10, 24'h555555, 1'b0, t);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (wr_pix.size() >= 37) break;
    end
    check("mr_pre_count", 64'(wr_pix.size()), 64'd37);
    reset = 1'b1;
    #1;
    check("mr_write", 64'(sig_write), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_ready", 64'(cmd_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mr_ready_rel", 64'(cmd_ready), 64'd1);
    repeat (20) @(negedge clk);
    #1;
    check("mr_no_more", 64'(wr_pix.size()), 64'd37);
    run_cmd(11'd5, 10'd5, 11'd1, 10'd1, 24'hABCDEF, t, d);
    check("mr_new_count", 64'(wr_pix.size()), 64'd1);
    if (wr_pix.size() == 1) check("mr_new_pix", 64'(wr_pix[0]), 64'd4005);

    // Back-to-back with cmd_valid held; fields change while busy
    @(negedge clk);
    clear_log();
    issue(11'd10, 10'd0, 11'd3, 10'd1, 24'h0000AA, 1'b1, t);
    cmd_x = 11'd0; cmd_y = 10'd1; cmd_w = 11'd1; cmd_h = 10'd2; cmd_color = 24'h0000BB;
    t2 = -1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        t2 = cyc;
        break;
      end
      @(negedge clk);
    end
    check("bb_gap", 64'(t2), 64'(t + 6));
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(d);
    check("bb_count", 64'(wr_pix.size()), 64'd5);
    if (wr_pix.size() == 5) begin
      check("bb_p0", 64'(wr_pix[0]), 64'd10);
      check("bb_p1", 64'(wr_pix[1]), 64'd11);
      check("bb_p2", 64'(wr_pix[2]), 64'd12);
      check("bb_col0", 64'(wr_col[2]), 64'h0000AA);
      check("bb_p3", 64'(wr_pix[3]), 64'd800);
      check("bb_p4", 64'(wr_pix[4]), 64'd1600);
      check("bb_col1", 64'(wr_col[4]), 64'h0000BB);
      check("bb_c3", 64'(wr_cyc[3]), 64'(t2 + 2));
    end
    check("bb_done", 64'(d), 64'(t2 + 4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
